// File: rtl/bp_update_ctrl.sv
// Branch predictor update controller: owns the global history register and serialises every
// PHT/BTB write (post-reset/clear init sweep and queued resolved-branch updates) onto one port.
module bp_update_ctrl #(
    parameter int DBITS   = 32,
    parameter int BPBITS  = 8,
    parameter int BTBBITS = 4,
    parameter int QDEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 de_br_valid,
    input  logic                 de_pred_taken,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic                 upd_taken,
    input  logic                 upd_mispred,
    input  logic [BPBITS-1:0]    upd_hist,
    input  logic [DBITS-1:0]     upd_pc,
    input  logic [DBITS-1:0]     upd_target,
    input  logic                 bp_clear,
    output logic [BPBITS-1:0]    bhr,
    output logic                 pht_wr_en,
    output logic [BPBITS-1:0]    pht_wr_idx,
    output logic [1:0]           pht_wr_op,
    output logic                 btb_wr_en,
    output logic [BTBBITS-1:0]   btb_wr_idx,
    output logic [DBITS+26:0]    btb_wr_data,
    output logic                 fetch_stall
);

    localparam int QW = $clog2(QDEPTH);
    localparam int CW = QW + 1;
    localparam logic [CW-1:0]     Q_FULL    = CW'(QDEPTH);
    localparam logic [BPBITS-1:0] CTR_LAST  = '1;
    localparam logic [BPBITS-1:0] BTB_SWEEP = BPBITS'(2 ** BTBBITS);
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [BPBITS-1:0]   ctr_q, ctr_d;
    logic [BPBITS-1:0]   bhr_q, bhr_d;
    logic [QW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                upd_ready_q, upd_ready_d;
    logic                fetch_stall_q, fetch_stall_d;
    logic                pht_wr_en_q, pht_wr_en_d;
    logic [BPBITS-1:0]   pht_wr_idx_q, pht_wr_idx_d;
    logic [1:0]          pht_wr_op_q, pht_wr_op_d;
    logic                btb_wr_en_q, btb_wr_en_d;
    logic [BTBBITS-1:0]  btb_wr_idx_q, btb_wr_idx_d;
    logic [DBITS+26:0]   btb_wr_data_q, btb_wr_data_d;

    // Only the 26-bit tag of the PC is kept; it also covers every index bit.
    logic                q_taken  [QDEPTH];
    logic [BPBITS-1:0]   q_hist   [QDEPTH];
    logic [25:0]         q_tag    [QDEPTH];
    logic [DBITS-1:0]    q_target [QDEPTH];

    logic                push, pop;
    logic                head_taken;
    logic [BPBITS-1:0]   head_hist;
    logic [25:0]         head_tag;
    logic [DBITS-1:0]    head_target;
    logic                unused_pc_hi;

    assign unused_pc_hi = ^upd_pc[DBITS-1:26];

    always_ff @(posedge clk) begin
        if (push) begin
            q_taken[wr_ptr_q]  <= upd_taken;
            q_hist[wr_ptr_q]   <= upd_hist;
            q_tag[wr_ptr_q]    <= upd_pc[25:0];
            q_target[wr_ptr_q] <= upd_target;
        end
    end

    always_comb begin
        push        = upd_valid && upd_ready_q;
        pop         = (state_q != ST_INIT) && (count_q != '0);
        head_taken  = q_taken[rd_ptr_q];
        head_hist   = q_hist[rd_ptr_q];
        head_tag    = q_tag[rd_ptr_q];
        head_target = q_target[rd_ptr_q];

        state_d       = state_q;
        ctr_d         = ctr_q;
        bhr_d         = bhr_q;
        wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d       = count_q;
        pht_wr_en_d   = 1'b0;
        pht_wr_idx_d  = '0;
        pht_wr_op_d   = 2'b00;
        btb_wr_en_d   = 1'b0;
        btb_wr_idx_d  = '0;
        btb_wr_data_d = '0;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop) begin
            pht_wr_en_d  = 1'b1;
            pht_wr_idx_d = head_tag[BPBITS+1:2] ^ head_hist;
            pht_wr_op_d  = head_taken ? OP_INC : OP_DEC;
            if (head_taken) begin
                btb_wr_en_d   = 1'b1;
                btb_wr_idx_d  = head_tag[BTBBITS+1:2];
                btb_wr_data_d = {head_tag, 1'b1, head_target};
            end
        end

        // A mispredict repair replaces the history outright, so it wins over a DE shift.
        if (state_q != ST_INIT) begin
            if (push && upd_mispred) begin
                bhr_d = {upd_hist[BPBITS-2:0], upd_taken};
            end else if (de_br_valid) begin
                bhr_d = {bhr_q[BPBITS-2:0], de_pred_taken};
            end
        end

        case (state_q)
            ST_INIT: begin
                pht_wr_en_d  = 1'b1;
                pht_wr_idx_d = ctr_q;
                pht_wr_op_d  = OP_LOAD;
                if (ctr_q < BTB_SWEEP) begin
                    btb_wr_en_d  = 1'b1;
                    btb_wr_idx_d = ctr_q[BTBBITS-1:0];
                end
                ctr_d = ctr_q + 1'b1;
                if (ctr_q == CTR_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bp_clear) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_q == '0) begin
                    state_d = ST_INIT;
                    ctr_d   = '0;
                    bhr_d   = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase

        upd_ready_d   = (state_d == ST_RUN) && (count_d < Q_FULL);
        fetch_stall_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_INIT;
            ctr_q         <= '0;
            bhr_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            upd_ready_q   <= 1'b0;
            fetch_stall_q <= 1'b1;
            pht_wr_en_q   <= 1'b0;
            pht_wr_idx_q  <= '0;
            pht_wr_op_q   <= 2'b00;
            btb_wr_en_q   <= 1'b0;
            btb_wr_idx_q  <= '0;
            btb_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            ctr_q         <= ctr_d;
            bhr_q         <= bhr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            upd_ready_q   <= upd_ready_d;
            fetch_stall_q <= fetch_stall_d;
            pht_wr_en_q   <= pht_wr_en_d;
            pht_wr_idx_q  <= pht_wr_idx_d;
            pht_wr_op_q   <= pht_wr_op_d;
            btb_wr_en_q   <= btb_wr_en_d;
            btb_wr_idx_q  <= btb_wr_idx_d;
            btb_wr_data_q <= btb_wr_data_d;
        end
    end

    assign upd_ready   = upd_ready_q;
    assign fetch_stall = fetch_stall_q;
    assign bhr         = bhr_q;
    assign pht_wr_en   = pht_wr_en_q;
    assign pht_wr_idx  = pht_wr_idx_q;
    assign pht_wr_op   = pht_wr_op_q;
    assign btb_wr_en   = btb_wr_en_q;
    assign btb_wr_idx  = btb_wr_idx_q;
    assign btb_wr_data = btb_wr_data_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Testbench for bp_update_ctrl: every predictor write is checked against a scoreboard queue
// filled when stimulus is driven; BHR and handshake outputs are checked directly.
module tb_bp_update_ctrl;

    localparam int DBITS   = 32;
    localparam int BPBITS  = 8;
    localparam int BTBBITS = 4;
    localparam int QDEPTH  = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                de_br_valid, de_pred_taken;
    logic                upd_valid, upd_ready, upd_taken, upd_mispred;
    logic [BPBITS-1:0]   upd_hist;
    logic [DBITS-1:0]    upd_pc, upd_target;
    logic                bp_clear;
    logic [BPBITS-1:0]   bhr;
    logic                pht_wr_en;
    logic [BPBITS-1:0]   pht_wr_idx;
    logic [1:0]          pht_wr_op;
    logic                btb_wr_en;
    logic [BTBBITS-1:0]  btb_wr_idx;
    logic [DBITS+26:0]   btb_wr_data;
    logic                fetch_stall;

    typedef struct packed {
        logic [7:0]  idx;
        logic [1:0]  op;
        logic        ben;
        logic [3:0]  bidx;
        logic [58:0] bdata;
    } wr_t;

    typedef struct {
        logic [31:0] pc;
        logic [7:0]  hist;
        logic        taken;
        logic        mispred;
        logic [31:0] target;
        logic [7:0]  exp_idx;
        logic [1:0]  exp_op;
        logic        exp_ben;
        logic [3:0]  exp_bidx;
        logic [7:0]  exp_bhr;
    } vec_t;

    wr_t  sb[$];
    vec_t vecs[5];
    int   compared   = 0;
    int   mismatched = 0;

    bp_update_ctrl #(
        .DBITS(DBITS), .BPBITS(BPBITS), .BTBBITS(BTBBITS), .QDEPTH(QDEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .de_br_valid(de_br_valid), .de_pred_taken(de_pred_taken),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_taken(upd_taken), .upd_mispred(upd_mispred),
        .upd_hist(upd_hist), .upd_pc(upd_pc), .upd_target(upd_target),
        .bp_clear(bp_clear), .bhr(bhr),
        .pht_wr_en(pht_wr_en), .pht_wr_idx(pht_wr_idx), .pht_wr_op(pht_wr_op),
        .btb_wr_en(btb_wr_en), .btb_wr_idx(btb_wr_idx), .btb_wr_data(btb_wr_data),
        .fetch_stall(fetch_stall)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    function automatic wr_t expWrite(input logic [31:0] pc, input logic [7:0] hist,
                                     input logic taken, input logic [31:0] target);
        wr_t w;
        w.idx   = pc[9:2] ^ hist;
        w.op    = taken ? 2'b01 : 2'b10;
        w.ben   = taken;
        w.bidx  = taken ? pc[5:2] : 4'h0;
        w.bdata = taken ? {pc[25:0], 1'b1, target} : 59'h0;
        return w;
    endfunction

    task automatic pushSweep();
        for (int i = 0; i < 256; i++) begin
            wr_t w;
            logic [7:0] iv;
            iv      = i[7:0];
            w.idx   = iv;
            w.op    = 2'b11;
            w.ben   = (i < 16);
            w.bidx  = (i < 16) ? iv[3:0] : 4'h0;
            w.bdata = 59'h0;
            sb.push_back(w);
        end
    endtask

    // Every write the DUT emits must match the oldest outstanding expectation.
    always @(negedge clk) begin
        wr_t act, want;
        if (reset) begin
            checkOutput("btb_write_without_pht", 128'(btb_wr_en && !pht_wr_en), 128'(0));
            if (pht_wr_en) begin
                act = {pht_wr_idx, pht_wr_op, btb_wr_en,
                       btb_wr_en ? btb_wr_idx : 4'h0, btb_wr_en ? btb_wr_data : 59'h0};
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_write: got %0h, expected no write", act);
                end else begin
                    want = sb.pop_front();
                    checkOutput("table_write", 128'(act), 128'(want));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] pc, input logic [7:0] hist, input logic taken,
                                 input logic mispred, input logic [31:0] target,
                                 input logic de_v, input logic de_p);
        upd_valid     = 1'b1;
        upd_pc        = pc;
        upd_hist      = hist;
        upd_taken     = taken;
        upd_mispred   = mispred;
        upd_target    = target;
        de_br_valid   = de_v;
        de_pred_taken = de_p;
        @(posedge clk); #1;
        upd_valid     = 1'b0;
        upd_mispred   = 1'b0;
        de_br_valid   = 1'b0;
        de_pred_taken = 1'b0;
    endtask

    task automatic deShift(input logic p);
        de_br_valid   = 1'b1;
        de_pred_taken = p;
        @(posedge clk); #1;
        de_br_valid   = 1'b0;
        de_pred_taken = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("queue_drained", 128'(sb.size()), 128'(0));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_fetch_stall"}, 128'(fetch_stall), 128'(1));
        checkOutput({tag, "_upd_ready"},   128'(upd_ready),   128'(0));
        checkOutput({tag, "_bhr"},         128'(bhr),         128'(0));
        checkOutput({tag, "_pht_wr_en"},   128'(pht_wr_en),   128'(0));
        checkOutput({tag, "_pht_wr_op"},   128'(pht_wr_op),   128'(0));
        checkOutput({tag, "_btb_wr_en"},   128'(btb_wr_en),   128'(0));
    endtask

    // Counts cycles until fetch_stall drops; optionally pokes bp_clear and an
    // unacceptable mispredict into the middle of the sweep.
    task automatic measureStall(output int n, input bit disturb);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 100) begin
                checkOutput("stall_mid_sweep", 128'(fetch_stall), 128'(1));
                checkOutput("ready_mid_sweep", 128'(upd_ready),   128'(0));
            end
            if (disturb && n == 50) bp_clear = 1'b1;
            if (disturb && n == 51) bp_clear = 1'b0;
            if (disturb && n == 60) begin
                upd_valid = 1'b1; upd_mispred = 1'b1; upd_hist = 8'hFF;
                upd_taken = 1'b1; upd_pc = 32'h40; upd_target = 32'h0;
            end
            if (disturb && n == 61) begin
                upd_valid = 1'b0; upd_mispred = 1'b0;
                checkOutput("bhr_no_repair_when_not_ready", 128'(bhr), 128'(0));
            end
        end while (fetch_stall && n < 400);
    endtask

    initial begin
        int n;
        vecs[0] = '{32'h0000_0040, 8'h05, 1'b1, 1'b0, 32'h0000_0100, 8'h15, 2'b01, 1'b1, 4'h0, 8'h00};
        vecs[1] = '{32'h0000_1234, 8'hAA, 1'b0, 1'b1, 32'h0000_0000, 8'h27, 2'b10, 1'b0, 4'h0, 8'h54};
        vecs[2] = '{32'hFFFF_FFFC, 8'hFF, 1'b1, 1'b1, 32'hDEAD_BEEF, 8'h00, 2'b01, 1'b1, 4'hF, 8'hFF};
        vecs[3] = '{32'h0000_0208, 8'h00, 1'b1, 1'b0, 32'h0000_0400, 8'h82, 2'b01, 1'b1, 4'h2, 8'hFF};
        vecs[4] = '{32'h8000_0010, 8'h3C, 1'b0, 1'b1, 32'h0000_0000, 8'h38, 2'b10, 1'b0, 4'h0, 8'h78};

        reset = 1'b1;
        de_br_valid = 1'b0; de_pred_taken = 1'b0;
        upd_valid = 1'b0; upd_taken = 1'b0; upd_mispred = 1'b0;
        upd_hist = '0; upd_pc = '0; upd_target = '0; bp_clear = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");

        reset = 1'b1;
        pushSweep();
        measureStall(n, 1'b0);
        checkOutput("sweep_cycles", 128'(n), 128'(256));
        @(posedge clk); #1;
        checkOutput("sweep_complete", 128'(sb.size()), 128'(0));
        checkOutput("ready_after_sweep", 128'(upd_ready), 128'(1));
        checkOutput("stall_after_sweep", 128'(fetch_stall), 128'(0));

        for (int i = 0; i < 5; i++) begin
            wr_t w;
            w.idx   = vecs[i].exp_idx;
            w.op    = vecs[i].exp_op;
            w.ben   = vecs[i].exp_ben;
            w.bidx  = vecs[i].exp_bidx;
            w.bdata = vecs[i].exp_ben ? {vecs[i].pc[25:0], 1'b1, vecs[i].target} : 59'h0;
            checkOutput("vec_upd_ready", 128'(upd_ready), 128'(1));
            sb.push_back(w);
            applyStimulus(vecs[i].pc, vecs[i].hist, vecs[i].taken, vecs[i].mispred,
                          vecs[i].target, 1'b0, 1'b0);
            checkOutput("vec_bhr", 128'(bhr), 128'(vecs[i].exp_bhr));
            waitDrain();
        end

        sb.push_back(expWrite(32'h40, 8'h81, 1'b0, 32'h0));
        applyStimulus(32'h40, 8'h81, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
        checkOutput("bhr_repair_beats_de", 128'(bhr), 128'(8'h02));
        waitDrain();
        deShift(1'b1);
        checkOutput("bhr_de_shift_1", 128'(bhr), 128'(8'h05));
        deShift(1'b0);
        checkOutput("bhr_de_shift_0", 128'(bhr), 128'(8'h0A));
        deShift(1'b1);
        checkOutput("bhr_de_shift_1b", 128'(bhr), 128'(8'h15));
        sb.push_back(expWrite(32'h300, 8'h11, 1'b1, 32'h500));
        applyStimulus(32'h300, 8'h11, 1'b1, 1'b0, 32'h500, 1'b1, 1'b0);
        checkOutput("bhr_de_with_good_update", 128'(bhr), 128'(8'h2A));
        waitDrain();

        for (int i = 0; i < 6; i++) begin
            logic [31:0] pc;
            logic [7:0]  hist;
            logic        tk;
            pc   = 32'h1000 + 32'(i * 36);
            hist = 8'(i * 19);
            tk   = (i % 2) == 0;
            checkOutput("b2b_upd_ready", 128'(upd_ready), 128'(1));
            sb.push_back(expWrite(pc, hist, tk, 32'h2000 + 32'(i)));
            applyStimulus(pc, hist, tk, 1'b0, 32'h2000 + 32'(i), 1'b0, 1'b0);
        end
        waitDrain();
        checkOutput("b2b_bhr_held", 128'(bhr), 128'(8'h2A));

        sb.push_back(expWrite(32'h80, 8'h00, 1'b1, 32'h1234));
        bp_clear = 1'b1;
        applyStimulus(32'h80, 8'h00, 1'b1, 1'b0, 32'h1234, 1'b0, 1'b0);
        bp_clear = 1'b0;
        checkOutput("clear_stall", 128'(fetch_stall), 128'(1));
        checkOutput("clear_ready", 128'(upd_ready), 128'(0));
        pushSweep();
        measureStall(n, 1'b1);
        checkOutput("clear_total_cycles", 128'(n), 128'(258));
        repeat (5) @(posedge clk);
        #1;
        checkOutput("clear_complete", 128'(sb.size()), 128'(0));
        checkOutput("clear_bhr", 128'(bhr), 128'(0));

        reset = 1'b0;
        #1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        pushSweep();
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkResetState("midsweep");
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        pushSweep();
        measureStall(n, 1'b0);
        checkOutput("restart_sweep_cycles", 128'(n), 128'(256));
        @(posedge clk); #1;
        checkOutput("restart_sweep_complete", 128'(sb.size()), 128'(0));

        sb.push_back(expWrite(vecs[0].pc, vecs[0].hist, vecs[0].taken, vecs[0].target));
        applyStimulus(vecs[0].pc, vecs[0].hist, vecs[0].taken, vecs[0].mispred,
                      vecs[0].target, 1'b0, 1'b0);
        checkOutput("post_reset_bhr", 128'(bhr), 128'(0));
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
